rv32_pc_ctrl_mh: RTL

- Multi-hart PC controller for the barrel core. Holds one PC register per hart and issues fetch PCs round-robin across enabled, awake harts.
- Resolves branch, JAL, JALR, AUIPC and MRET results from execute. Applies IRQ redirects per hart.
- Sits between the CSR/IRQ unit, the execute stage and the instruction-memory fetch port.
- Generalises single-hart next-PC calculation: per-hart state, WFI sleep, registered fetch/writeback outputs.

---
 rtl/rv32_pc_ctrl_mh.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rv32_pc_ctrl_mh.sv
// rv32_pc_ctrl_mh: per-hart PC registers, round-robin fetch scheduler, execute/IRQ redirect and WFI sleep.
// Optional PITO_PC_MISALIGN_CHK_EN traps misaligned redirect targets instead of clearing bits[1:0].
package rv32_pc_ctrl_mh_pkg;
    typedef enum logic [3:0] {
        RV32_OP, RV32_LUI, RV32_AUIPC, RV32_JAL, RV32_JALR,
        RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU,
        RV32_MRET, RV32_WFI
    } rv32_opcode_enum_t;
endpackage

module rv32_pc_ctrl_mh
    import rv32_pc_ctrl_mh_pkg::*;
#(
    parameter int NUM_HARTS = 8,
    parameter int HART_W = $clog2(NUM_HARTS),
    parameter int PC_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_HARTS-1:0] hart_en,
    input  logic                 fetch_stall,
    output logic                 fetch_valid,
    output logic [HART_W-1:0]    fetch_hart_id,
    output logic [PC_W-1:0]      fetch_pc,
    input  logic                 ex_valid,
    input  logic [HART_W-1:0]    ex_hart_id,
    input  rv32_opcode_enum_t    ex_opcode,
    input  logic [PC_W-1:0]      ex_cur_pc,
    input  logic [31:0]          ex_rs1,
    input  logic [31:0]          ex_imm,
    input  logic [31:0]          ex_alu_res,
    input  logic                 irq_valid,
    input  logic [HART_W-1:0]    irq_hart_id,
    input  logic [PC_W-1:0]      irq_pc,
    output logic                 wb_save_pc,
    output logic [HART_W-1:0]    wb_hart_id,
    output logic [31:0]          wb_reg_pc,
    output logic                 wb_redirect,
    output logic [NUM_HARTS-1:0] hart_sleep
`ifdef PITO_PC_MISALIGN_CHK_EN
    ,
    output logic                 misalign_valid,
    output logic [HART_W-1:0]    misalign_hart_id,
    output logic [PC_W-1:0]      misalign_addr
`endif
);
    typedef enum logic {RUN, SLEEP} hart_state_e;
    hart_state_e state_q [NUM_HARTS];
    hart_state_e state_d [NUM_HARTS];
    logic [PC_W-1:0] pc_q [NUM_HARTS];
    logic [NUM_HARTS-1:0] elig;
    logic [HART_W-1:0] rr_ptr, pick, idx;
    logic found, redirect, bad, save;
    logic [PC_W-1:0] imm_pc, raw_tgt, tgt;
    logic [31:0] save_val;

    assign imm_pc = PC_W'(ex_imm);
    assign redirect = ex_valid && ((ex_opcode inside {RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU}
                      && ex_alu_res == 32'd1) || ex_opcode inside {RV32_JAL, RV32_JALR, RV32_MRET});
    assign raw_tgt = ex_opcode == RV32_JALR ? (PC_W'(ex_rs1) + imm_pc) & ~PC_W'(1) :
                     ex_opcode == RV32_MRET ? irq_pc : ex_cur_pc + imm_pc;
    assign save = ex_valid && ex_opcode inside {RV32_JAL, RV32_JALR, RV32_AUIPC};
    assign save_val = 32'(ex_opcode == RV32_AUIPC ? ex_cur_pc + imm_pc : ex_cur_pc + PC_W'(4));

`ifdef PITO_PC_MISALIGN_CHK_EN
    assign bad = redirect && raw_tgt[1:0] != 2'b00;
    assign tgt = raw_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_valid <= 1'b0;
            misalign_hart_id <= '0;
            misalign_addr <= '0;
        end else begin
            misalign_valid <= bad;
            misalign_hart_id <= bad ? ex_hart_id : '0;
            misalign_addr <= bad ? raw_tgt : '0;
        end
    end
`else
    assign bad = 1'b0;
    assign tgt = {raw_tgt[PC_W-1:2], 2'b00};
`endif

    // IRQ wakes a hart even if it executes WFI (or faults) in the same cycle
    always_comb begin
        elig = '0;
        hart_sleep = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            state_d[h] = irq_valid && irq_hart_id == HART_W'(h) ? RUN :
                         ex_valid && ex_hart_id == HART_W'(h) && (ex_opcode == RV32_WFI || bad) ? SLEEP : state_q[h];
            elig[h] = hart_en[h] && state_q[h] == RUN;
            hart_sleep[h] = state_q[h] == SLEEP;
        end
    end

    // rr_ptr itself is searched last so a lone eligible hart is picked every cycle
    always_comb begin
        found = 1'b0;
        pick = rr_ptr;
        idx = rr_ptr;
        for (int i = 1; i <= NUM_HARTS; i++) begin
            idx = rr_ptr + HART_W'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= HART_W'(NUM_HARTS - 1);
            fetch_valid <= 1'b0;
            fetch_hart_id <= '0;
            fetch_pc <= '0;
            wb_save_pc <= 1'b0;
            wb_hart_id <= '0;
            wb_reg_pc <= '0;
            wb_redirect <= 1'b0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                pc_q[h] <= RESET_PC;
                state_q[h] <= RUN;
            end
        end else begin
            if (!fetch_stall) begin
                fetch_valid <= found;
                if (found) begin
                    fetch_hart_id <= pick;
                    fetch_pc <= pc_q[pick];
                    rr_ptr <= pick;
                end
            end
            wb_save_pc <= save;
            wb_hart_id <= ex_valid ? ex_hart_id : '0;
            wb_reg_pc <= save ? save_val : '0;
            wb_redirect <= redirect && !bad;
            for (int h = 0; h < NUM_HARTS; h++) begin
                state_q[h] <= state_d[h];
                pc_q[h] <= irq_valid && irq_hart_id == HART_W'(h) ? irq_pc :
                           redirect && !bad && ex_hart_id == HART_W'(h) ? tgt :
                           !fetch_stall && found && pick == HART_W'(h) ? pc_q[h] + PC_W'(4) : pc_q[h];
            end
        end
    end
endmodule
